prog_loader: RTL and testbench

Program-memory loader for the 14-bit-instruction CPU core. It accepts a byte stream through a valid/ready handshake and packs each byte pair into a 14-bit instruction word. Each word is written sequentially into the external program memory. A framed, checksummed session replaces the program image, and the loader holds the CPU in reset until the image is complete and verified.

---
 rtl/prog_loader_pkg.sv | 19 +
 rtl/prog_loader_if.sv | 25 ++
 rtl/prog_loader.sv | 147 ++++++++++++++
 tb/tb_prog_loader.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program-memory loader.
package prog_loader_pkg;

  localparam int INSTR_W = 14;
  localparam int HI_BITS = 6;

  typedef enum logic [3:0] {
    IDLE,
    CNT_HI,
    CNT_LO,
    W_HI,
    W_LO,
    WRITE,
    CHK,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream handshake plus program-memory write port of the loader.
interface prog_loader_if
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = 11
);

  logic               byte_valid;
  logic [7:0]         byte_data;
  logic               byte_ready;
  logic               pm_we;
  logic [ADDR_W-1:0]  pm_addr;
  logic [INSTR_W-1:0] pm_wdata;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, pm_we, pm_addr, pm_wdata
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, pm_we, pm_addr, pm_wdata
  );

endinterface

// File: rtl/prog_loader.sv
// Framed, checksummed program loader: packs byte pairs into 14-bit words,
// writes them sequentially to program memory and holds the CPU until verified.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W    = 11,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  prog_loader_if.slave      bus,
  output logic              cpu_hold,
  output logic [ADDR_W:0]   word_count,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [31:0]       MAX_WORDS = 32'd1 << ADDR_W;

  state_t              state;
  logic [7:0]          cnt_hi;
  logic [7:0]          csum;
  logic [15:0]         n_words;
  logic [HI_BITS-1:0]  hi_bits;

  logic                xfer;
  logic [7:0]          csum_next;
  logic [15:0]         n_rx;
  logic [ADDR_W:0]     idx_next;
  logic                last_word;

  assign xfer      = bus.byte_valid && bus.byte_ready;
  assign csum_next = csum + bus.byte_data;
  assign n_rx      = {cnt_hi, bus.byte_data};
  assign idx_next  = word_count + (ADDR_W+1)'(1);
  assign last_word = (32'(idx_next) == 32'(n_words));

  // word_count doubles as the write index; pm_addr is re-registered whenever
  // the index moves so it always equals BASE + index without an adder on the output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      bus.byte_ready <= 1'b0;
      bus.pm_we      <= 1'b0;
      bus.pm_addr    <= BASE;
      bus.pm_wdata   <= '0;
      cpu_hold       <= 1'b0;
      word_count     <= '0;
      done           <= 1'b0;
      err            <= 1'b0;
      csum           <= '0;
      cnt_hi         <= '0;
      n_words        <= '0;
      hi_bits        <= '0;
    end else begin
      bus.pm_we <= 1'b0;
      if (xfer) csum <= csum_next;

      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state          <= CNT_HI;
            bus.byte_ready <= 1'b1;
            cpu_hold       <= 1'b1;
            done           <= 1'b0;
            err            <= 1'b0;
            csum           <= '0;
            word_count     <= '0;
            bus.pm_addr    <= BASE;
          end
        end

        CNT_HI: begin
          if (xfer) begin
            cnt_hi <= bus.byte_data;
            state  <= CNT_LO;
          end
        end

        CNT_LO: begin
          if (xfer) begin
            n_words <= n_rx;
            if (n_rx != 16'd0 && 32'(n_rx) <= MAX_WORDS) begin
              state <= W_HI;
            end else begin
              state          <= ERR;
              err            <= 1'b1;
              bus.byte_ready <= 1'b0;
            end
          end
        end

        W_HI: begin
          if (xfer) begin
            if (bus.byte_data[7:6] == 2'b00) begin
              hi_bits <= bus.byte_data[HI_BITS-1:0];
              state   <= W_LO;
            end else begin
              state          <= ERR;
              err            <= 1'b1;
              bus.byte_ready <= 1'b0;
            end
          end
        end

        W_LO: begin
          if (xfer) begin
            bus.pm_wdata   <= {hi_bits, bus.byte_data};
            bus.pm_we      <= 1'b1;
            bus.byte_ready <= 1'b0;
            state          <= WRITE;
          end
        end

        WRITE: begin
          word_count     <= idx_next;
          bus.pm_addr    <= BASE + idx_next[ADDR_W-1:0];
          bus.byte_ready <= 1'b1;
          state          <= last_word ? CHK : W_HI;
        end

        CHK: begin
          if (xfer) begin
            bus.byte_ready <= 1'b0;
            if (csum_next == 8'd0) begin
              state    <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= ERR;
              err   <= 1'b1;
            end
          end
        end

        default: begin
          state          <= IDLE;
          bus.byte_ready <= 1'b0;
          cpu_hold       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader.
module tb_prog_loader;

  localparam int ADDR_W = 11;

  typedef logic [7:0] bytes_t[$];

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            cpu_hold;
  logic [ADDR_W:0] word_count;
  logic            done;
  logic            err;

  int total = 0;
  int bad   = 0;

  logic [ADDR_W-1:0] wr_addr[$];
  logic [13:0]       wr_data[$];

  prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

  prog_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bus        (bus.slave),
    .cpu_hold   (cpu_hold),
    .word_count (word_count),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.pm_we === 1'b1) begin
      wr_addr.push_back(bus.pm_addr);
      wr_data.push_back(bus.pm_wdata);
      check("ready_in_write", 32'(bus.byte_ready), 32'd0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int stall);
    int n = 0;
    for (int i = 0; i < stall; i++) begin
      bus.byte_valid = 1'($urandom_range(1, 0)) & 1'b0;
      bus.byte_data  = 8'($urandom);
      @(negedge clk);
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    while (bus.byte_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_frame(input bytes_t q, input int max_stall);
    foreach (q[i]) send_byte(q[i], (max_stall == 0) ? 0 : int'($urandom_range(max_stall, 0)));
  endtask

  function automatic bytes_t add_csum(input bytes_t q);
    logic [7:0] s = 8'd0;
    bytes_t r = q;
    foreach (q[i]) s = s + q[i];
    r.push_back(8'd0 - s);
    return r;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic check_reset_outputs();
    check("rst_ready", 32'(bus.byte_ready), 32'd0);
    check("rst_we",    32'(bus.pm_we),      32'd0);
    check("rst_addr",  32'(bus.pm_addr),    32'd0);
    check("rst_wdata", 32'(bus.pm_wdata),   32'd0);
    check("rst_hold",  32'(cpu_hold),       32'd0);
    check("rst_count", 32'(word_count),     32'd0);
    check("rst_done",  32'(done),           32'd0);
    check("rst_err",   32'(err),            32'd0);
  endtask

  task automatic check_nominal_writes(input string tag);
    check({tag, "_nwr"}, 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      check({tag, "_a0"}, 32'(wr_addr[0]), 32'h000);
      check({tag, "_d0"}, 32'(wr_data[0]), 32'h3005);
      check({tag, "_a1"}, 32'(wr_addr[1]), 32'h001);
      check({tag, "_d1"}, 32'(wr_data[1]), 32'h3E03);
    end
  endtask

  initial begin
    bytes_t nominal  = '{8'h00, 8'h02, 8'h30, 8'h05, 8'h3E, 8'h03, 8'h88};
    bytes_t bad_sum  = '{8'h00, 8'h02, 8'h30, 8'h05, 8'h3E, 8'h03, 8'h89};
    bytes_t q;
    int     errs;

    rst = 1'b1;
    start = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    @(negedge clk);

    // Nominal load
    clear_log();
    pulse_start();
    check("start_ready", 32'(bus.byte_ready), 32'd1);
    check("start_hold",  32'(cpu_hold),       32'd1);
    send_frame(nominal, 0);
    check("nom_done",  32'(done),       32'd1);
    check("nom_err",   32'(err),        32'd0);
    check("nom_hold",  32'(cpu_hold),   32'd0);
    check("nom_count", 32'(word_count), 32'd2);
    check_nominal_writes("nom");

    // Bad checksum
    clear_log();
    pulse_start();
    send_frame(bad_sum, 0);
    check("bsum_err",  32'(err),      32'd1);
    check("bsum_done", 32'(done),     32'd0);
    check("bsum_hold", 32'(cpu_hold), 32'd1);
    check_nominal_writes("bsum");

    // Zero count
    clear_log();
    pulse_start();
    send_frame('{8'h00, 8'h00}, 0);
    check("cnt0_err", 32'(err), 32'd1);
    check("cnt0_nwr", 32'(wr_addr.size()), 32'd0);
    check("cnt0_ready", 32'(bus.byte_ready), 32'd0);

    // Count one past capacity
    pulse_start();
    send_frame('{8'h08, 8'h01}, 0);
    check("cnt2049_err", 32'(err), 32'd1);
    check("cnt2049_nwr", 32'(wr_addr.size()), 32'd0);

    // Bad high byte
    pulse_start();
    send_frame('{8'h00, 8'h01, 8'h45}, 0);
    check("hi45_err", 32'(err), 32'd1);
    check("hi45_hold", 32'(cpu_hold), 32'd1);
    repeat (3) @(negedge clk);
    check("hi45_nwr", 32'(wr_addr.size()), 32'd0);

    // Backpressure / stalls, plus start ignored mid-session
    clear_log();
    pulse_start();
    send_frame('{8'h00, 8'h02, 8'h30}, 3);
    pulse_start();
    check("mid_start_hold", 32'(cpu_hold), 32'd1);
    send_frame('{8'h05, 8'h3E, 8'h03, 8'h88}, 3);
    check("stall_done",  32'(done),       32'd1);
    check("stall_count", 32'(word_count), 32'd2);
    check_nominal_writes("stall");

    // Full memory: N = 2048
    clear_log();
    q = '{8'h08, 8'h00};
    for (int i = 0; i < 2048; i++) begin
      q.push_back(8'((i >> 8) & 8'h3F));
      q.push_back(8'(i & 8'hFF));
    end
    q = add_csum(q);
    pulse_start();
    send_frame(q, 0);
    check("full_done",  32'(done),       32'd1);
    check("full_count", 32'(word_count), 32'd2048);
    check("full_nwr",   32'(wr_addr.size()), 32'd2048);
    errs = 0;
    if (wr_addr.size() == 2048) begin
      check("full_last_addr", 32'(wr_addr[2047]), 32'h7FF);
      check("full_last_data", 32'(wr_data[2047]), 32'h7FF);
      for (int i = 0; i < 2048; i++)
        if (int'(wr_addr[i]) != i || int'(wr_data[i]) != i) errs++;
    end
    check("full_seq", 32'(errs), 32'd0);

    // Reset mid-session, in the WRITE cycle of the third word
    clear_log();
    pulse_start();
    send_frame('{8'h00, 8'h05, 8'h01, 8'h11, 8'h02, 8'h22, 8'h03, 8'h33}, 0);
    check("mid_we", 32'(bus.pm_we), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs();
    check("mid_nwr", 32'(wr_addr.size()), 32'd3);
    if (wr_addr.size() == 3) begin
      check("mid_a2", 32'(wr_addr[2]), 32'h002);
      check("mid_d2", 32'(wr_data[2]), 32'h0333);
    end
    repeat (2) @(negedge clk);
    check("idle_start_ignored_ready", 32'(bus.byte_ready), 32'd0);

    // Restart from ERR then a clean frame
    pulse_start();
    send_frame('{8'h00, 8'h00}, 0);
    check("re_err", 32'(err), 32'd1);
    clear_log();
    pulse_start();
    check("re_err_clr", 32'(err), 32'd0);
    send_frame(nominal, 0);
    check("re_done", 32'(done), 32'd1);
    check_nominal_writes("re");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
